// File: rtl/div_u_seq.sv
`default_nettype none
// ============================================================================
// Module      : div_u_seq
// Description : Iterative unsigned restoring divider (DIVU/REMU). Resolves one
//               quotient bit per clock with a start/valid handshake. A zero
//               divisor takes a one-cycle shortcut that returns all-ones
//               quotient and the dividend as remainder (RISC-V semantics).
//               Optional macro DIV_U_SEQ_KILL_EN adds a 'kill' input that
//               aborts an operation in flight without disturbing results.
// Revision    : 1.0 - initial release
// ============================================================================
module div_u_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef DIV_U_SEQ_KILL_EN
    input  logic             kill,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_zero = 2'd2;

    localparam logic [CNT_W-1:0] c_count_init = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_count_one  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_rem;      // partial remainder
    logic [WIDTH-1:0] r_dq;       // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] r_dvs;      // captured divisor
    logic             r_valid;

    logic             w_kill;
    logic             w_last;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_dq_next;

`ifdef DIV_U_SEQ_KILL_EN
    assign w_kill = kill;
`else
    assign w_kill = 1'b0;
`endif

    // Final iteration: the counter is on its last step this edge
    assign w_last = (r_state == c_st_run) && (r_count == c_count_one);

    // One restoring step: shift in next dividend bit, trial-subtract at WIDTH+1 bits
    // so a set MSB of the shifted remainder never overflows.
    assign w_shifted  = {r_rem, r_dq[WIDTH-1]};
    assign w_diff     = w_shifted - {1'b0, r_dvs};
    assign w_qbit     = ~w_diff[WIDTH];
    assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    assign w_dq_next  = {r_dq[WIDTH-2:0], w_qbit};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; kill wins over completion
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_next = (divisor == '0) ? c_st_zero : c_st_run;
                end
            end
            c_st_run: begin
                if (w_kill || w_last) begin
                    w_state_next = c_st_idle;
                end
            end
            c_st_zero: begin
                w_state_next = c_st_idle;
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // Output decode: busy whenever an operation is in flight
    always_comb begin
        busy = (r_state != c_st_idle);
    end

    assign valid = r_valid;

    // Datapath: operand capture, iteration, and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_rem       <= '0;
            r_dq        <= '0;
            r_dvs       <= '0;
            r_valid     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_dq    <= dividend;
                        r_dvs   <= divisor;
                        r_rem   <= '0;
                        r_count <= (divisor == '0) ? '0 : c_count_init;
                    end
                end
                c_st_run: begin
                    if (!w_kill) begin
                        r_rem   <= w_rem_next;
                        r_dq    <= w_dq_next;
                        r_count <= r_count - c_count_one;
                        if (w_last) begin
                            quotient    <= w_dq_next;
                            remainder   <= w_rem_next;
                            div_by_zero <= 1'b0;
                            r_valid     <= 1'b1;
                        end
                    end
                end
                c_st_zero: begin
                    if (!w_kill) begin
                        quotient    <= '1;
                        remainder   <= r_dq;
                        div_by_zero <= 1'b1;
                        r_valid     <= 1'b1;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/div_u_seq.md
Name: div_u_seq

Overview:
- Iterative unsigned restoring divider; the inverse operation of the unsigned multiplier used by the M-extension datapath.
- Serves DIVU/REMU in the execute-stage M unit.
- One quotient bit resolved per clock, with a start/valid handshake to the issuing control.
- Results held stable until the next operation completes.

Parameters:
- WIDTH, 32, operand width in bits (>= 4); quotient and remainder are WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- dividend  input  WIDTH  numerator; captured on accepted start.
- divisor  input  WIDTH  denominator; captured on accepted start.
- busy  output  1  operation in progress; start ignored while high.
- valid  output  1  one-cycle pulse; quotient/remainder/div_by_zero valid from this cycle on.
- quotient  output  WIDTH  floor(dividend/divisor).
- remainder  output  WIDTH  dividend mod divisor.
- div_by_zero  output  1  set with valid when the captured divisor was 0; held with results.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0, internal registers=0. Reset mid-operation aborts it; no valid is produced.
- States:
  - IDLE: on start=1 with divisor!=0, capture operands, clear the partial remainder, set count=WIDTH, busy=1, go to RUN.
  - IDLE, start=1 with divisor==0: go to ZERO, busy=1.
  - RUN: each edge, shift {partial remainder, dividend shift reg} left 1 and trial-subtract the divisor (WIDTH+1-bit subtract).
    - Non-negative result: keep the difference and shift in quotient bit 1.
    - Negative result: restore and shift in quotient bit 0.
    - Decrement count. On the edge where count reaches 0, register quotient/remainder, clear div_by_zero, valid=1, busy=0, go to IDLE.
  - ZERO: one edge later, quotient=all ones, remainder=captured dividend, div_by_zero=1, valid=1, busy=0, go to IDLE. This matches RISC-V DIVU/REMU semantics.
- Latency: accepted start at edge E0 gives valid high in the cycle after edge E(WIDTH) (normal) or E1 (divide by zero).
- Throughput: start may be asserted during the valid cycle (busy=0) and is accepted at that edge. Back-to-back operations therefore cost WIDTH+1 cycles each.
- valid is high for exactly one cycle per accepted start and is never asserted otherwise.
- start while busy=1 is ignored; operand inputs are don't-care outside the accepting edge.
- Boundaries:
  - dividend < divisor gives q=0, r=dividend.
  - divisor=1 gives q=dividend, r=0.
  - dividend=0 gives q=0, r=0 with full latency.
  - Maximum operands: no overflow, because the trial subtract is WIDTH+1 bits.
- Outputs quotient/remainder/div_by_zero change only on the valid edge or on reset.

Optional Feature:
- Macro DIV_U_SEQ_KILL_EN.
- Defined: adds input port kill (1 bit, after start).
  - kill=1 at any edge while busy=1 returns the block to IDLE with busy=0, no valid, and previous results untouched.
  - kill takes priority over completion at the same edge.
  - kill in IDLE has no effect; start is still accepted if kill and start arrive together in IDLE.
  - Used for pipeline flush on branch mispredict or trap.
- Not defined: port absent; every accepted start completes.

Test Plan:
1. Reset mid-run: start 100/7, assert rst_n=0 at cycle 10 -> all outputs 0 immediately, no valid after release; then start 100/7 -> valid after 32 cycles, q=14, r=2, div_by_zero=0.
2. Divide by zero: dividend=0x1234_5678, divisor=0 -> valid one cycle after start, q=0xFFFF_FFFF, r=0x1234_5678, div_by_zero=1, total busy time 1 cycle.
3. Extremes:
   - 0xFFFF_FFFF/1 -> q=0xFFFF_FFFF, r=0.
   - 0xFFFF_FFFF/0xFFFF_FFFF -> q=1, r=0.
   - 5/9 -> q=0, r=5.
   - 0/3 -> q=0, r=0.
   - Each with valid exactly 32 cycles after start.
4. Back-to-back and ignored start:
   - Hold start high continuously with operands changing each cycle -> only operands at accepting edges used.
   - One valid pulse every 33 cycles.
   - Starts during busy produce no extra valid.
5. Random: 10k random operand pairs vs reference model (q=a/b, r=a%b, b=0 per case 2); exactly one valid per accepted start; outputs stable between valids.
6. (DIV_U_SEQ_KILL_EN) start 1000/3, kill at cycle 5 -> busy=0 next cycle, no valid, q/r keep prior values; kill together with start in IDLE -> operation proceeds, valid after 32 cycles.
